// File: rtl/axi4_rw_test_if.sv
// ---------------------------------------------------------------------------
// axi4_ifc -- AXI4 bus bundle, 32-bit data, parameterised ID width.
//
// Purpose : Groups every AXI4 channel signal used by the read/write test
//           master. Only the subset this generator drives or samples is
//           present (no lock/qos/region/user).
// Modports:
//   master - drives AW/W/AR request channels plus bready/rready, samples
//            the ready and response signals from the slave.
//   slave  - the mirror image, used by memory models and bus fabric.
// ---------------------------------------------------------------------------
interface axi4_ifc #(
  parameter int IWIDTH = 5
);

  // Write address channel
  logic [IWIDTH-1:0] awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  // Write data channel
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  // Write response channel
  logic [IWIDTH-1:0] bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  // Read address channel
  logic [IWIDTH-1:0] arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  // Read data channel
  logic [IWIDTH-1:0] rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_rw_test.sv
// ---------------------------------------------------------------------------
// axi4_rw_test -- AXI4 master traffic generator and read-back checker.
//
// Purpose : Writes NBURSTS incrementing bursts of BURSTLEN words, each word
//           being {addr[31:2],2'b00} ^ SEED, then reads the same region
//           back and compares every beat. MODE selects write+check (0),
//           write only (1) or check only (2). One transaction is in flight
//           at a time, so AW/W and AR/R never overlap.
// Ports   :
//   clk        - sole clock
//   reset      - synchronous, active-high
//   start      - one-cycle pulse, begins a pass when idle or done
//   busy       - high from start acceptance until the pass completes
//   done       - high once the pass completes, held until the next start
//   error      - sticky fail flag for the current pass
//   err_count  - number of mismatching read beats, saturates at 16'hFFFF
//   m          - AXI4 master port (axi4_ifc.master)
// ---------------------------------------------------------------------------
module axi4_rw_test #(
  parameter logic [31:0] BASE     = 32'h0000_0000,
  parameter int          BURSTLEN = 8,
  parameter int          NBURSTS  = 4,
  parameter logic [31:0] SEED     = 32'h5A5A_0000,
  parameter int          MODE     = 0,
  parameter int          IWIDTH   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] err_count,
  axi4_ifc.master     m
);

  localparam logic [7:0]  LAST_BEAT   = 8'(BURSTLEN - 1);
  localparam logic [8:0]  LAST_BURST  = 9'(NBURSTS - 1);
  localparam logic [31:0] BURST_BYTES = 32'(BURSTLEN * 4);

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    AR,
    R,
    DONE
  } state_t;

  state_t      state_q;
  logic [31:0] burstAddr_q;
  logic [31:0] beatAddr_q;
  logic [7:0]  beat_q;
  logic [8:0]  burst_q;
  logic        awValid_q;
  logic        wValid_q;
  logic [31:0] wData_q;
  logic        wLast_q;
  logic        bReady_q;
  logic        arValid_q;
  logic        rReady_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] errCount_q;

  logic [31:0] beatAddr_d;
  logic [31:0] burstAddr_d;
  logic [31:0] expWord_d;
  logic        unusedIds;

  // Word expected at any byte address: word-aligned address XOR the seed.
  function automatic logic [31:0] pattern(input logic [31:0] addr);
    return {addr[31:2], 2'b00} ^ SEED;
  endfunction

  // Address arithmetic shared by the write and read phases. Bursts are
  // contiguous, so the word after the last beat of one burst is the first
  // word of the next; the read compare uses the current beat address.
  always_comb begin
    beatAddr_d  = beatAddr_q + 32'd4;
    burstAddr_d = burstAddr_q + BURST_BYTES;
    expWord_d   = pattern(beatAddr_q);
  end

  // Response IDs are not checked since every request uses ID 0.
  assign unusedIds = ^{m.bid, m.rid};

  // Main sequencer. Every bus output is a register updated here, so the
  // valid/ready lines never glitch and stay stable until their handshake.
  // A start is only honoured in IDLE or DONE; while busy it is dropped.
  // Entering a request state raises that channel's valid on the same edge,
  // which gives the one-cycle start-to-valid latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      burstAddr_q <= BASE;
      beatAddr_q  <= BASE;
      beat_q      <= '0;
      burst_q     <= '0;
      awValid_q   <= 1'b0;
      wValid_q    <= 1'b0;
      wData_q     <= '0;
      wLast_q     <= 1'b0;
      bReady_q    <= 1'b0;
      arValid_q   <= 1'b0;
      rReady_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      errCount_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            errCount_q  <= '0;
            burstAddr_q <= BASE;
            beatAddr_q  <= BASE;
            beat_q      <= '0;
            burst_q     <= '0;
            if (MODE == 2) begin
              state_q   <= AR;
              arValid_q <= 1'b1;
            end else begin
              state_q   <= AW;
              awValid_q <= 1'b1;
            end
          end
        end

        AW: begin
          if (m.awready) begin
            awValid_q <= 1'b0;
            wValid_q  <= 1'b1;
            wData_q   <= pattern(beatAddr_q);
            wLast_q   <= (LAST_BEAT == 8'd0);
            beat_q    <= '0;
            state_q   <= W;
          end
        end

        W: begin
          // Data and wlast only move on an accepted beat, so they hold
          // through any number of wready stalls.
          if (m.wready) begin
            beatAddr_q <= beatAddr_d;
            if (beat_q == LAST_BEAT) begin
              wValid_q <= 1'b0;
              wLast_q  <= 1'b0;
              bReady_q <= 1'b1;
              state_q  <= B;
            end else begin
              beat_q  <= beat_q + 8'd1;
              wData_q <= pattern(beatAddr_d);
              wLast_q <= ((beat_q + 8'd1) == LAST_BEAT);
            end
          end
        end

        B: begin
          if (m.bvalid) begin
            bReady_q <= 1'b0;
            if (m.bresp != 2'b00) begin
              error_q <= 1'b1;
            end
            if (burst_q == LAST_BURST) begin
              burst_q <= '0;
              if (MODE == 1) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                burstAddr_q <= BASE;
                beatAddr_q  <= BASE;
                arValid_q   <= 1'b1;
                state_q     <= AR;
              end
            end else begin
              burst_q     <= burst_q + 9'd1;
              burstAddr_q <= burstAddr_d;
              beatAddr_q  <= burstAddr_d;
              awValid_q   <= 1'b1;
              state_q     <= AW;
            end
          end
        end

        AR: begin
          if (m.arready) begin
            arValid_q  <= 1'b0;
            rReady_q   <= 1'b1;
            beat_q     <= '0;
            beatAddr_q <= burstAddr_q;
            state_q    <= R;
          end
        end

        R: begin
          // The burst always ends on rlast, even when it arrives on the
          // wrong beat; a misplaced or missing rlast only flags the error.
          if (m.rvalid) begin
            if (m.rdata != expWord_d) begin
              error_q <= 1'b1;
              if (errCount_q != 16'hFFFF) begin
                errCount_q <= errCount_q + 16'd1;
              end
            end
            if (m.rresp != 2'b00) begin
              error_q <= 1'b1;
            end
            if (m.rlast != (beat_q == LAST_BEAT)) begin
              error_q <= 1'b1;
            end
            if (m.rlast) begin
              rReady_q    <= 1'b0;
              burstAddr_q <= burstAddr_d;
              beatAddr_q  <= burstAddr_d;
              if (burst_q == LAST_BURST) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                burst_q   <= burst_q + 9'd1;
                arValid_q <= 1'b1;
                state_q   <= AR;
              end
            end else begin
              beatAddr_q <= beatAddr_d;
              if (beat_q != 8'hFF) begin
                beat_q <= beat_q + 8'd1;
              end
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_count = errCount_q;

  // Request channels: fixed INCR bursts of full 32-bit words, ID 0.
  assign m.awid    = {IWIDTH{1'b0}};
  assign m.awaddr  = burstAddr_q;
  assign m.awlen   = LAST_BEAT;
  assign m.awsize  = 3'd2;
  assign m.awburst = 2'b01;
  assign m.awcache = 4'd0;
  assign m.awprot  = 3'd0;
  assign m.awvalid = awValid_q;

  assign m.wdata   = wData_q;
  assign m.wstrb   = 4'hF;
  assign m.wlast   = wLast_q;
  assign m.wvalid  = wValid_q;

  assign m.bready  = bReady_q;

  assign m.arid    = {IWIDTH{1'b0}};
  assign m.araddr  = burstAddr_q;
  assign m.arlen   = LAST_BEAT;
  assign m.arsize  = 3'd2;
  assign m.arburst = 2'b01;
  assign m.arcache = 4'd0;
  assign m.arprot  = 3'd0;
  assign m.arvalid = arValid_q;

  assign m.rready  = rReady_q;

endmodule
